// File: rtl/inst_imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the I/S/B/U/J fields of an
// instruction template, expands LI into ADDI / LUI / LUI+ADDI, one output stage.
module inst_imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmt,
  input  logic [31:0]      req_base,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {S_RUN, S_LI2} state_e;

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_J  = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd5;

  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic               out_err_q, out_err_d;
  logic [31:0]        pend_q, pend_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               out_fire;
  logic               fits12;
  logic               fits13;
  logic               fits21;
  logic               lo_zero;
  logic [4:0]         rd;
  logic [19:0]        li_hi;
  logic [31:0]        enc_inst;
  logic [31:0]        enc_pend;
  logic               enc_err;
  logic               enc_two;

  assign accept   = req_valid && req_ready;
  assign out_fire = out_valid_q && out_ready;

  // A value fits N signed bits when every bit above N-2 equals the sign bit.
  assign fits12  = (req_imm[31:11] == {21{req_imm[11]}});
  assign fits13  = (req_imm[31:12] == {20{req_imm[12]}});
  assign fits21  = (req_imm[31:20] == {12{req_imm[20]}});
  assign lo_zero = (req_imm[11:0] == 12'd0);
  assign rd      = req_base[11:7];
  // Upper part is rounded so that LUI(hi) + sext(lo) reproduces imm exactly.
  assign li_hi   = req_imm[31:12] + {19'd0, req_imm[11]};

  // ------------------------------------------------------------------------
  // Request encoder
  // ------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    enc_inst = req_base;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = {req_imm[11:0], rd, 3'b000, rd, OPC_ADDI};
    case (req_fmt)
      FMT_I: begin
        enc_inst = {req_imm[11:0], req_base[19:0]};
        enc_err  = !fits12;
      end
      FMT_S: begin
        enc_inst = {req_imm[11:5], req_base[24:12], req_imm[4:0], req_base[6:0]};
        enc_err  = !fits12;
      end
      FMT_B: begin
        enc_inst = {req_imm[12], req_imm[10:5], req_base[24:12],
                    req_imm[4:1], req_imm[11], req_base[6:0]};
        enc_err  = !fits13 || req_imm[0];
      end
      FMT_U: begin
        enc_inst = {req_imm[31:12], req_base[11:0]};
        enc_err  = !lo_zero;
      end
      FMT_J: begin
        enc_inst = {req_imm[20], req_imm[10:1], req_imm[11],
                    req_imm[19:12], req_base[11:0]};
        enc_err  = !fits21 || req_imm[0];
      end
      FMT_LI: begin
        if (fits12) begin
          enc_inst = {req_imm[11:0], 5'd0, 3'b000, rd, OPC_ADDI};
        end else if (lo_zero) begin
          enc_inst = {req_imm[31:12], rd, OPC_LUI};
        end else begin
          enc_inst = {li_hi, rd, OPC_LUI};
          enc_two  = 1'b1;
        end
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: if (accept && enc_two) state_d = S_LI2;
      S_LI2: if (out_fire)          state_d = S_RUN;
      default:                      state_d = S_RUN;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  end

  // ------------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    pend_d      = pend_q;
    if (state_q == S_LI2) begin
      // LUI leaves, ADDI half takes its place without a bubble.
      if (out_fire) begin
        out_inst_d = pend_q;
        out_err_d  = 1'b0;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = enc_err;
      if (enc_two) pend_d = enc_pend;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    count_d = count_q + CNT_W'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_err_q   <= 1'b0;
      pend_q      <= 32'd0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      pend_q      <= pend_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_inst_imm_encoder.sv
// Scoreboard bench for inst_imm_encoder: driver pushes expected words, a monitor
// pops and compares on each output handshake; reference model works from imm rules.
module tb_inst_imm_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_fmt = 3'd0;
  logic [31:0]   req_base = 32'd0;
  logic [31:0]   req_imm = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] out_count;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        rt;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t          sb[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [CW-1:0] exp_count = '0;
  int            rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

  inst_imm_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmt   (req_fmt),
    .req_base  (req_base),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired pass=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Core immediate decode, used for the round-trip property.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] f);
    case (f)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'd0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] inst, input logic err);
    sb.push_back('{inst, err, 1'b0, 3'd0, 32'd0});
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [31:0] lo);
    return ((lo & 32'hFFF) << 20) | (32'(rs) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [31:0] up);
    return (up & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
  endfunction

  // Reference model: range checks on the signed value, fields placed by masks.
  task automatic model_push(input logic [2:0] f, input logic [31:0] b, input logic [31:0] imm);
    int          s;
    logic        err;
    logic [31:0] inst;
    logic [31:0] lo;
    logic [4:0]  rd;
    s    = int'(imm);
    rd   = b[11:7];
    err  = 1'b0;
    inst = b;
    case (f)
      3'd0: begin
        err  = (s < -2048) || (s > 2047);
        inst = (b & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
      end
      3'd1: begin
        err  = (s < -2048) || (s > 2047);
        inst = (b & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        err  = (s < -4096) || (s > 4094) || imm[0];
        inst = (b & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
             | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        err  = (imm % 4096) != 0;
        inst = (b & 32'hFFF) | (imm & 32'hFFFFF000);
      end
      3'd4: begin
        err  = (s < -1048576) || (s > 1048574) || imm[0];
        inst = (b & 32'hFFF) | (((imm >> 20) & 32'h1) << 31)
             | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
             | (((imm >> 12) & 32'hFF) << 12);
      end
      3'd5: begin
        lo = {{20{imm[11]}}, imm[11:0]};
        if (s >= -2048 && s <= 2047) begin
          sb.push_back('{addi(rd, 5'd0, lo), 1'b0, 1'b0, f, imm});
        end else if (lo == 32'd0) begin
          sb.push_back('{lui(rd, imm), 1'b0, 1'b0, f, imm});
        end else begin
          sb.push_back('{lui(rd, imm - lo), 1'b0, 1'b0, f, imm});
          sb.push_back('{addi(rd, rd, lo), 1'b0, 1'b0, f, imm});
        end
      end
      default: err = 1'b1;
    endcase
    if (f != 3'd5) sb.push_back('{inst, err, !err && (f <= 3'd4), f, imm});
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    bit done;
    done = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_fmt   = f;
    req_base  = b;
    req_imm   = i;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL req_accept_timeout fmt=%0d imm=%h", f, i);
      req_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    rdy_mode = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
    end
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(9, 0) < 7);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: count tracking, hold stability, scoreboard pop on handshake
  initial begin
    exp_t        it;
    logic        hold;
    logic [31:0] hold_inst;
    logic        hold_err;
    hold = 1'b0;
    hold_inst = 32'd0;
    hold_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      check("out_count", 32'(out_count), 32'(exp_count));
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_inst", out_inst, hold_inst);
        check("hold_err", 32'(out_err), 32'(hold_err));
      end
      hold      = out_valid && !out_ready;
      hold_inst = out_inst;
      hold_err  = out_err;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output got=%h exp=none", out_inst);
        end else begin
          it = sb.pop_front();
          check("out_inst", out_inst, it.inst);
          check("out_err", 32'(out_err), 32'(it.err));
          if (it.rt) check("roundtrip", decode(out_inst, it.fmt), it.imm);
        end
        exp_count = exp_count + 1'b1;
      end
    end
  end

  logic [2:0]    bf  [16] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
                              3'd4, 3'd4, 3'd4, 3'd3, 3'd5, 3'd5, 3'd5, 3'd7};
  logic [31:0]   bim [16] = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF,
                              32'hFFE, 32'hFFFFF000, 32'h1000, 32'hFFF00000,
                              32'hFFFFE, 32'h100000, 32'h5, 32'hFFFFF000,
                              32'hFFFFF800, 32'h800, 32'h7FFFFFFF, 32'h0};

  initial begin
    logic [CW-1:0] mc0;
    logic [2:0]    f;
    logic [31:0]   b;
    logic [31:0]   imm;
    int            v;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    // Directed vectors with fixed expectations
    issue(3'd0, 32'h00000093, 32'hFFFFFFFF); push_exp(32'hFFF00093, 1'b0);
    issue(3'd2, 32'h00000063, 32'd2048);     push_exp(32'h000000E3, 1'b0);
    issue(3'd2, 32'h00000063, 32'd3);        push_exp(32'h00000163, 1'b1);
    issue(3'd5, 32'h00000280, 32'h12345FFF); push_exp(32'h123462B7, 1'b0);
                                             push_exp(32'hFFF28293, 1'b0);
    issue(3'd5, 32'h00000280, 32'd100);      push_exp(32'h06400293, 1'b0);
    issue(3'd5, 32'h00000280, 32'h00010000); push_exp(32'h000102B7, 1'b0);
    issue(3'd3, 32'h000002B7, 32'h12345001); push_exp(32'h123452B7, 1'b1);
    issue(3'd6, 32'hDEADBEEF, 32'h00000010); push_exp(32'hDEADBEEF, 1'b1);
    idle();
    wait_drain();

    // Range boundaries through the model
    for (int k = 0; k < 16; k++) begin
      issue(bf[k], 32'hA5A5A5A5 ^ 32'(k), bim[k]);
      model_push(bf[k], 32'hA5A5A5A5 ^ 32'(k), bim[k]);
    end
    idle();
    wait_drain();

    // Back-pressure across both LI words
    mc0 = exp_count;
    rdy_mode = 2;
    issue(3'd5, 32'h00000280, 32'h12345FFF);
    push_exp(32'h123462B7, 1'b0);
    push_exp(32'hFFF28293, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_inst", out_inst, 32'h123462B7);
    end
    wait_drain();
    check("bp_count_plus2", 32'(out_count), 32'(mc0 + 2'd2));

    // Reset while the ADDI half is pending
    rdy_mode = 2;
    issue(3'd5, 32'h00000280, 32'h12345FFF);
    push_exp(32'h123462B7, 1'b0);
    push_exp(32'hFFF28293, 1'b0);
    idle();
    @(negedge clk);
    check("li2_blocked", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    sb.delete();
    exp_count = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_inst", out_inst, 32'd0);
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_addi_after_rst", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random back-pressure
    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      f = 3'($urandom_range(7, 0));
      b = $urandom;
      case (f)
        3'd0, 3'd1: v = int'($urandom_range(4095, 0)) - 2048;
        3'd2:       v = (int'($urandom_range(4095, 0)) - 2048) * 2;
        3'd4:       v = (int'($urandom_range(1048575, 0)) - 524288) * 2;
        3'd3:       v = int'($urandom & 32'hFFFFF000);
        3'd5:       v = ($urandom_range(1, 0) == 0) ? int'($urandom_range(4095, 0)) - 2048
                                                     : int'($urandom);
        default:    v = int'($urandom);
      endcase
      imm = 32'(v);
      if ($urandom_range(4, 0) == 0) imm = $urandom;
      if (f == 3'd5 && $urandom_range(5, 0) == 0) imm = imm & 32'hFFFFF000;
      issue(f, b, imm);
      model_push(f, b, imm);
      if ($urandom_range(3, 0) == 0) idle();
    end
    idle();
    wait_drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
